simon_input_arbiter: RTL and testbench
======================================

Name: simon_input_arbiter

Overview:
- Conditions the four raw pad buttons for the Simon game core and feeds it single, clean presses.
- Each button is synchronised and debounced. One winner is selected when several buttons press in the same cycle.
- Emits one 1-cycle player_pressed pulse with a 2-bit player_num per physical press; the button must be released before another press is accepted.
- Sits between the board buttons and the Simon core's playerNum/playerPressed inputs. Gated by the core's turn and game-over outputs.

Parameters:
- DEBOUNCE_TICKS, 3, consecutive clk cycles a synchronised button must differ from its debounced value before that value flips (3 = 50 ms at 60 Hz).
- STUCK_TICKS, 180, cycles in HOLD before a stuck-button error is flagged (3 s at 60 Hz).
- Counter widths are $clog2(param+1).

Ports:
- clk  input  1  system clock (60 Hz game tick)
- reset  input  1  asynchronous, active-high reset
- btn  input  4  raw pad buttons, bit i = pad i, active-high, asynchronous
- enable  input  1  player may press; driven by inverted simonTurn
- game_over  input  1  from core; suppresses all grants
- player_num  output  2  index of last granted pad; held between grants
- player_pressed  output  1  one-cycle grant pulse
- btn_held  output  1  OR of the debounced button states
- stuck_error  output  1  high while in STUCK

Behaviour:
- Reset (async, active-high) clears all of the following:
  - sync flops, debounced state, debounce counters, stuck counter;
  - player_num=0, player_pressed=0, btn_held=0, stuck_error=0;
  - rr_last=3, so pad 0 has first priority;
  - FSM goes to WAIT_REL.
  - Reset mid-press restarts debounce from the released state.
- Synchroniser: 2 flops per bit; sync[i] is valid 2 edges after raw change.
- Debounce, per bit:
  - When sync[i] != deb[i], cnt[i] increments. When it reaches DEBOUNCE_TICKS, deb[i] takes sync[i] and cnt[i] clears.
  - When sync[i] == deb[i], cnt[i] clears, so glitches shorter than DEBOUNCE_TICKS are rejected.
- btn_held = |deb, registered.
- FSM states:
  - WAIT_REL: wait until deb == 0, then go to ARMED.
  - ARMED:
    - If game_over or !enable, go to WAIT_REL.
    - Else if deb != 0, pick a winner, go to PRESS, and register player_num=winner and player_pressed=1 on that same edge.
  - PRESS: lasts one cycle. player_pressed returns to 0. rr_last=player_num. Go to HOLD. Clear stuck counter.
  - HOLD:
    - If deb == 0, go to ARMED (or WAIT_REL if !enable or game_over).
    - Otherwise increment the stuck counter. When it equals STUCK_TICKS-1, go to STUCK.
  - STUCK: stuck_error=1. When deb == 0, clear stuck_error and go to WAIT_REL.
- Arbitration is rotating priority. Search starts at (rr_last+1) mod 4 and wraps, and the first set deb bit wins. Example: rr_last=1 with deb=4'b1011 grants pad 3.
- Presses of other pads during HOLD are ignored. All pads must be released before the next grant.
- player_pressed is never high on two consecutive cycles. At most one pulse per physical press.
- Latency: a clean raw rise sampled at edge 0 gives deb set at edge 2+DEBOUNCE_TICKS, and player_pressed high after edge 3+DEBOUNCE_TICKS (edge 6 at defaults). Precondition: FSM is in ARMED with enable=1 and game_over=0.
- enable falling during PRESS does not cancel the pulse already issued.
- game_over has priority over enable in every state.

Test Plan:
- Reset, then raise btn=4'b0100 for 10 cycles -> player_pressed high exactly 1 cycle, after edge 6; player_num=2; btn_held=1 from edge 5.
- Raise btn[1] for 2 cycles only (glitch) -> no change to deb, btn_held=0, no pulse.
- After reset, btn=4'b1001 simultaneous -> grant 0. Release, then press 4'b1001 again -> grant 3. Release, then press again -> grant 0.
- Hold btn[0], then raise btn[2] mid-hold, release both, wait -> exactly one pulse (num 0), none for pad 2.
- enable=0 while btn=4'b0010 pressed, then raise enable with button still held -> no pulse until release. A re-press afterwards pulses once with num 1.
- Hold btn[3] for 200 cycles -> stuck_error rises at HOLD+180 cycles. Release -> stuck_error clears after debounce with no pulse. A game_over=1 press gives no pulse at all.

Source files
------------

// File: rtl/simon_input_arbiter.sv
// Button conditioner for the Simon core: sync, debounce, rotating-priority
// arbitration and one grant pulse per physical press, with stuck-button detection.
module simon_input_arbiter #(
    parameter int DEBOUNCE_TICKS = 3,
    parameter int STUCK_TICKS    = 180
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic       enable,
    input  logic       game_over,
    output logic [1:0] player_num,
    output logic       player_pressed,
    output logic       btn_held,
    output logic       stuck_error
);

    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int SW = $clog2(STUCK_TICKS + 1);

    localparam logic [2:0] WAIT_REL = 3'd0;
    localparam logic [2:0] ARMED    = 3'd1;
    localparam logic [2:0] PRESS    = 3'd2;
    localparam logic [2:0] HOLD     = 3'd3;
    localparam logic [2:0] STUCK    = 3'd4;

    logic [3:0]    syncMeta;
    logic [3:0]    syncBtn;
    logic [3:0]    deb;
    logic [3:0]    debNext;
    logic [DW-1:0] debCnt     [4];
    logic [DW-1:0] debCntNext [4];
    logic [2:0]    state;
    logic [1:0]    rrLast;
    logic [1:0]    winner;
    logic [1:0]    idx;
    logic          found;
    logic          blocked;
    logic [SW-1:0] stuckCnt;

    assign blocked = game_over || !enable;

    // A bit flips only after its counter has already reached DEBOUNCE_TICKS
    // and the synchronised input still disagrees on the following edge.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            debNext[i]    = deb[i];
            debCntNext[i] = '0;
            if (syncBtn[i] != deb[i]) begin
                if (debCnt[i] == DW'(DEBOUNCE_TICKS)) begin
                    debNext[i] = syncBtn[i];
                end else begin
                    debCntNext[i] = debCnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        winner = rrLast;
        idx    = rrLast;
        found  = 1'b0;
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = rrLast + 2'(k);
            if (!found && deb[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            syncMeta <= '0;
            syncBtn  <= '0;
            deb      <= '0;
            btn_held <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                debCnt[i] <= '0;
            end
        end else begin
            syncMeta <= btn;
            syncBtn  <= syncMeta;
            deb      <= debNext;
            btn_held <= |debNext;
            for (int unsigned i = 0; i < 4; i++) begin
                debCnt[i] <= debCntNext[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= WAIT_REL;
            rrLast         <= 2'd3;
            player_num     <= '0;
            player_pressed <= 1'b0;
            stuck_error    <= 1'b0;
            stuckCnt       <= '0;
        end else begin
            case (state)
                WAIT_REL: begin
                    if (deb == '0) state <= ARMED;
                end
                ARMED: begin
                    if (blocked) begin
                        state <= WAIT_REL;
                    end else if (deb != '0) begin
                        player_num     <= winner;
                        player_pressed <= 1'b1;
                        state          <= PRESS;
                    end
                end
                PRESS: begin
                    player_pressed <= 1'b0;
                    rrLast         <= player_num;
                    stuckCnt       <= '0;
                    state          <= HOLD;
                end
                HOLD: begin
                    if (deb == '0) begin
                        state <= blocked ? WAIT_REL : ARMED;
                    end else if (stuckCnt == SW'(STUCK_TICKS - 1)) begin
                        stuck_error <= 1'b1;
                        state       <= STUCK;
                    end else begin
                        stuckCnt <= stuckCnt + 1'b1;
                    end
                end
                STUCK: begin
                    if (deb == '0) begin
                        stuck_error <= 1'b0;
                        state       <= WAIT_REL;
                    end
                end
                default: state <= WAIT_REL;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_input_arbiter.sv
// Randomised and directed bench for simon_input_arbiter against a behavioural
// model of the press/release rules.
module tb_simon_input_arbiter;

    localparam int DEB   = 3;
    localparam int STUCK = 180;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] btn = '0;
    logic       enable = 1'b1;
    logic       game_over = 1'b0;
    logic [1:0] player_num;
    logic       player_pressed;
    logic       btn_held;
    logic       stuck_error;

    simon_input_arbiter #(.DEBOUNCE_TICKS(DEB), .STUCK_TICKS(STUCK)) dut (
        .clk            (clk),
        .reset          (reset),
        .btn            (btn),
        .enable         (enable),
        .game_over      (game_over),
        .player_num     (player_num),
        .player_pressed (player_pressed),
        .btn_held       (btn_held),
        .stuck_error    (stuck_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the player is idle until released, ready, just granted,
    // holding, or flagged stuck.
    typedef enum int {M_RELEASE, M_READY, M_GRANTED, M_HOLDING, M_JAMMED} phase_t;
    phase_t mPhase;
    bit [3:0] mRaw1, mRaw2, mDeb;
    int mRun [4];
    int mLastWinner, mNum, mHeldFor;
    bit mPressed, mHeld, mJam;

    int pulses, lastNum, tickNo;
    bit prevPressed;

    task automatic checkVal(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPhase = M_RELEASE;
        mRaw1 = '0; mRaw2 = '0; mDeb = '0;
        for (int i = 0; i < 4; i++) mRun[i] = 0;
        mLastWinner = 3; mNum = 0; mHeldFor = 0;
        mPressed = 0; mHeld = 0; mJam = 0;
    endtask

    task automatic modelStep();
        bit [3:0] seen;
        bit [3:0] newDeb;
        seen = mDeb;
        newDeb = mDeb;
        for (int i = 0; i < 4; i++) begin
            if (mRaw2[i] != seen[i]) begin
                if (mRun[i] >= DEB) begin
                    newDeb[i] = mRaw2[i];
                    mRun[i] = 0;
                end else begin
                    mRun[i]++;
                end
            end else begin
                mRun[i] = 0;
            end
        end
        mRaw2 = mRaw1;
        mRaw1 = btn;
        case (mPhase)
            M_RELEASE: if (seen == 0) mPhase = M_READY;
            M_READY: begin
                if (game_over || !enable) mPhase = M_RELEASE;
                else if (seen != 0) begin
                    for (int k = 1; k <= 4; k++) begin
                        if (seen[(mLastWinner + k) % 4]) begin
                            mNum = (mLastWinner + k) % 4;
                            break;
                        end
                    end
                    mPressed = 1;
                    mPhase = M_GRANTED;
                end
            end
            M_GRANTED: begin
                mPressed = 0;
                mLastWinner = mNum;
                mHeldFor = 0;
                mPhase = M_HOLDING;
            end
            M_HOLDING: begin
                if (seen == 0) mPhase = (game_over || !enable) ? M_RELEASE : M_READY;
                else begin
                    mHeldFor++;
                    if (mHeldFor == STUCK) begin
                        mJam = 1;
                        mPhase = M_JAMMED;
                    end
                end
            end
            M_JAMMED: if (seen == 0) begin
                mJam = 0;
                mPhase = M_RELEASE;
            end
            default: mPhase = M_RELEASE;
        endcase
        mDeb = newDeb;
        mHeld = |newDeb;
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        tickNo++;
        checkVal("player_pressed", player_pressed, mPressed);
        checkVal("player_num", player_num, mNum);
        checkVal("btn_held", btn_held, mHeld);
        checkVal("stuck_error", stuck_error, mJam);
        checkVal("noDoublePulse", player_pressed & prevPressed, 0);
        prevPressed = player_pressed;
        if (player_pressed) begin
            pulses++;
            lastNum = player_num;
        end
    endtask

    task automatic runFor(input logic [3:0] b, input int n);
        btn = b;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic doReset();
        #1 reset = 1'b1;
        modelReset();
        #1;
        checkVal("rst player_num", player_num, 0);
        checkVal("rst player_pressed", player_pressed, 0);
        checkVal("rst btn_held", btn_held, 0);
        checkVal("rst stuck_error", stuck_error, 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        prevPressed = 0;
    endtask

    initial begin
        int heldAt, pressAt, jamAt, pressTick;
        tickNo = 0;
        modelReset();
        doReset();

        // latency from a clean rise
        pulses = 0; heldAt = -1; pressAt = -1;
        btn = 4'b0100;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (btn_held && heldAt < 0) heldAt = i;
            if (player_pressed && pressAt < 0) pressAt = i;
        end
        checkVal("lat btn_held tick", heldAt, 6);
        checkVal("lat pressed tick", pressAt, 7);
        runFor(4'b0000, 10);
        checkVal("lat pulses", pulses, 1);
        checkVal("lat num", lastNum, 2);

        // short glitch rejected
        pulses = 0;
        runFor(4'b0010, 2);
        runFor(4'b0000, 10);
        checkVal("glitch pulses", pulses, 0);

        // rotating priority on simultaneous presses
        doReset();
        for (int r = 0; r < 3; r++) begin
            pulses = 0;
            runFor(4'b1001, 10);
            runFor(4'b0000, 10);
            checkVal("rr pulses", pulses, 1);
            checkVal("rr num", lastNum, (r == 1) ? 3 : 0);
        end

        // second pad during hold is ignored
        pulses = 0;
        runFor(4'b0001, 10);
        runFor(4'b0101, 10);
        runFor(4'b0000, 10);
        checkVal("hold pulses", pulses, 1);
        checkVal("hold num", lastNum, 0);

        // press while disabled needs a release first
        pulses = 0;
        enable = 1'b0;
        runFor(4'b0010, 10);
        enable = 1'b1;
        runFor(4'b0010, 10);
        checkVal("en held pulses", pulses, 0);
        runFor(4'b0000, 10);
        runFor(4'b0010, 10);
        runFor(4'b0000, 10);
        checkVal("en repress pulses", pulses, 1);
        checkVal("en repress num", lastNum, 1);

        // stuck detection
        pulses = 0; pressTick = -1; jamAt = -1;
        btn = 4'b1000;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (player_pressed && pressTick < 0) pressTick = tickNo;
            if (stuck_error && jamAt < 0) jamAt = tickNo;
        end
        checkVal("stuck delay", jamAt - pressTick, STUCK + 1);
        pulses = 0;
        runFor(4'b0000, 10);
        checkVal("stuck cleared", stuck_error, 0);
        checkVal("stuck release pulses", pulses, 0);

        // game over blocks grants
        game_over = 1'b1;
        runFor(4'b0001, 10);
        runFor(4'b0000, 10);
        checkVal("gameover pulses", pulses, 0);
        game_over = 1'b0;

        // reset mid-press restarts debounce
        runFor(4'b0100, 4);
        doReset();
        pulses = 0;
        runFor(4'b0100, 10);
        runFor(4'b0000, 10);
        checkVal("midreset pulses", pulses, 1);

        // randomised segments
        for (int s = 0; s < 400; s++) begin
            logic [3:0] b;
            case ($urandom_range(0, 3))
                0: b = 4'b0000;
                1: b = 4'(1 << $urandom_range(0, 3));
                default: b = 4'($urandom_range(0, 15));
            endcase
            enable = ($urandom_range(0, 7) != 0);
            game_over = ($urandom_range(0, 15) == 0);
            runFor(b, $urandom_range(1, 10));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
